// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner:
// FSM encodings, matrix size and mode key codes.
package keypad_scanner_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [1:0] KS_SCAN     = 2'd0;
  localparam logic [1:0] KS_DEBOUNCE = 2'd1;
  localparam logic [1:0] KS_HELD     = 2'd2;
  localparam logic [1:0] KS_RELEASE  = 2'd3;

  // Codes the state controller maps to modes.
  localparam logic [3:0] KC_LIGHT = 4'h0;
  localparam logic [3:0] KC_DRAW  = 4'h1;
  localparam logic [3:0] KC_ERASE = 4'h2;
  localparam logic [3:0] KC_CLEAR = 4'h3;

  // Index of the lowest active-low column.
  function automatic logic [1:0] low_col(
    input logic [3:0] c
  );
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!c[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_divider.sv
// Free-running tick generator: one-clock pulse
// every DIV clocks. Shared with the display refresh.
module scan_divider #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce.
// Define KEY_REPEAT_EN for held-key auto-repeat.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_RATE    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW =
    (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEBOUNCE_TICKS - 1);

  logic                        w_tick;
  logic                        w_col_bit;
  logic                        w_any_low;
  logic [NUM_COLS-1:0]         r_sync1;
  logic [NUM_COLS-1:0]         r_col_s;
  logic [$clog2(NUM_ROWS)-1:0] r_row_idx;
  logic [1:0]                  r_state;
  logic [1:0]                  r_cand;
  logic [DW-1:0]               r_deb_cnt;
  logic [3:0]                  r_key_code;
  logic                        r_key_valid;
  logic                        r_key_down;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE)
    ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RATE = RW'(REPEAT_RATE);
  logic [RW-1:0] r_rep_cnt;
`else
  logic [31:0] w_unused_rep;
  assign w_unused_rep = REPEAT_DELAY ^ REPEAT_RATE;
`endif

  scan_divider #(
    .DIV (SCAN_DIV)
  ) u_div (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_tick (w_tick)
  );

  assign w_col_bit = r_col_s[r_cand];
  assign w_any_low = (r_col_s != 4'hF);
  assign row_out   = ~(4'b0001 << r_row_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

  // Two-stage synchroniser; idles high like the pull-ups.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'hF;
      r_col_s <= 4'hF;
    end else begin
      r_sync1 <= col_in;
      r_col_s <= r_sync1;
    end
  end

  // Scan/debounce FSM; every decision waits for a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= KS_SCAN;
      r_row_idx   <= '0;
      r_cand      <= '0;
      r_deb_cnt   <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep_cnt   <= REP_DLY;
`endif
    end else begin
      r_key_valid <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          KS_SCAN: begin
            if (!w_any_low) begin
              r_row_idx <= r_row_idx + 1'b1;
            end else begin
              r_cand    <= low_col(r_col_s);
              r_deb_cnt <= '0;
              r_state   <= KS_DEBOUNCE;
            end
          end
          KS_DEBOUNCE: begin
            if (w_col_bit) begin
              r_state   <= KS_SCAN;
              r_row_idx <= r_row_idx + 1'b1;
            end else if (r_deb_cnt == DEB_LAST) begin
              r_key_code  <= {r_row_idx, r_cand};
              r_key_valid <= 1'b1;
              r_key_down  <= 1'b1;
              r_state     <= KS_HELD;
`ifdef KEY_REPEAT_EN
              r_rep_cnt   <= REP_DLY;
`endif
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end
          KS_HELD: begin
            if (w_col_bit) begin
              r_deb_cnt <= '0;
              r_state   <= KS_RELEASE;
            end else begin
`ifdef KEY_REPEAT_EN
              if (r_rep_cnt <= RW'(1)) begin
                r_key_valid <= 1'b1;
                r_rep_cnt   <= REP_RATE;
              end else begin
                r_rep_cnt <= r_rep_cnt - 1'b1;
              end
`endif
            end
          end
          KS_RELEASE: begin
            if (!w_col_bit) begin
              r_state   <= KS_HELD;
`ifdef KEY_REPEAT_EN
              r_rep_cnt <= REP_DLY;
`endif
            end else if (r_deb_cnt == DEB_LAST) begin
              r_key_down <= 1'b0;
              r_state    <= KS_SCAN;
              r_row_idx  <= r_row_idx + 1'b1;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end
          default: r_state <= KS_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner:
// table-driven presses plus timing corner cases.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic       key_en  = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [3:0] key_mask = 4'h0;
  logic       frc_en  = 1'b0;
  logic [3:0] frc_val = 4'hF;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0] row;
    logic [3:0] mask;
    logic [3:0] code;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  assign col_in = frc_en ? frc_val
    : (key_en && row_out[key_row] == 1'b0) ? ~key_mask
    : 4'hF;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .REPEAT_DELAY   (5),
    .REPEAT_RATE    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_down(input logic lvl,
                           input string nm);
    int n;
    n = 0;
    while (key_down !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, key_down}, {31'd0, lvl});
  endtask

  task automatic wait_row(input logic [3:0] r,
                          input string nm);
    int n;
    n = 0;
    while (row_out !== r && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {28'd0, row_out}, {28'd0, r});
  endtask

  // Scoreboard: every pulse must match a queued code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got code %0h want none",
                 key_code);
      end else begin
        chk("pulse_code", {28'd0, key_code},
            {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] er;
    int k;
    int offs[4];

    tbl[0] = '{2'd2, 4'b0010, 4'h9};
    tbl[1] = '{2'd0, 4'b0101, KC_LIGHT};
    tbl[2] = '{2'd1, 4'b1100, 4'h6};
    tbl[3] = '{2'd3, 4'b0001, 4'hC};
    tbl[4] = '{2'd0, 4'b1000, KC_CLEAR};
    tbl[5] = '{2'd3, 4'b1000, 4'hF};
    offs   = '{20, 28, 36, 44};

    // reset and idle scan
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_row", {28'd0, row_out}, 32'hE);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_down", {31'd0, key_down}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      er = ~(4'b0001 << (i / 4));
      chk("idle_row", {28'd0, row_out}, {28'd0, er});
      @(negedge clk);
    end

    // table-driven presses
    for (int v = 0; v < 6; v++) begin
      key_row  = tbl[v].row;
      key_mask = tbl[v].mask;
      exp_q.push_back(tbl[v].code);
      key_en   = 1'b1;
      wait_down(1'b1, "press_down");
      chk("press_code", {28'd0, key_code},
          {28'd0, tbl[v].code});
      er = ~(4'b0001 << tbl[v].row);
      chk("press_row", {28'd0, row_out}, {28'd0, er});
      repeat (8) @(negedge clk);
      chk("held_row", {28'd0, row_out}, {28'd0, er});
      chk("held_down", {31'd0, key_down}, 32'h1);
      key_en = 1'b0;
      wait_down(1'b0, "release_down");
    end

    // one-tick bounce on row 2
    wait_row(4'b1101, "bnc_sync1");
    wait_row(4'b1011, "bnc_sync2");
    frc_en  = 1'b1;
    frc_val = 4'b1101;
    repeat (4) @(negedge clk);
    chk("bnc_hold_row", {28'd0, row_out}, 32'hB);
    frc_val = 4'hF;
    repeat (4) @(negedge clk);
    chk("bnc_resume_row", {28'd0, row_out}, 32'h7);
    chk("bnc_down", {31'd0, key_down}, 32'h0);
    frc_en = 1'b0;

    // release glitch then full release
    key_row  = 2'd2;
    key_mask = 4'b0010;
    exp_q.push_back(4'h9);
    key_en   = 1'b1;
    wait_down(1'b1, "gl_down");
    frc_en  = 1'b1;
    frc_val = 4'hF;
    repeat (4) @(negedge clk);
    chk("gl_down_a", {31'd0, key_down}, 32'h1);
    frc_val = 4'b1101;
    repeat (4) @(negedge clk);
    chk("gl_down_b", {31'd0, key_down}, 32'h1);
    chk("gl_row", {28'd0, row_out}, 32'hB);
    frc_val = 4'hF;
    repeat (15) @(negedge clk);
    chk("rel_still_down", {31'd0, key_down}, 32'h1);
    @(negedge clk);
    chk("rel_up", {31'd0, key_down}, 32'h0);
    chk("rel_row", {28'd0, row_out}, 32'h7);
    frc_en = 1'b0;
    key_en = 1'b0;

`ifdef KEY_REPEAT_EN
    // auto-repeat on a held key
    key_row  = 2'd1;
    key_mask = 4'b0001;
    exp_q.push_back(4'h4);
    key_en   = 1'b1;
    wait_down(1'b1, "rep_down");
    for (int j = 0; j < 4; j++) exp_q.push_back(4'h4);
    k = 0;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        if (k < 4) chk("rep_time", n, offs[k]);
        k++;
      end
    end
    chk("rep_count", k, 4);
    key_en = 1'b0;
    wait_down(1'b0, "rep_up");
`else
    k = 0;
    chk("offs_init", offs[0] + k, 20);
`endif

    // reset during DEBOUNCE
    wait_row(4'b0111, "md_sync1");
    wait_row(4'b1110, "md_sync2");
    key_row  = 2'd0;
    key_mask = 4'b0100;
    key_en   = 1'b1;
    repeat (9) @(negedge clk);
    chk("md_row_held", {28'd0, row_out}, 32'hE);
    chk("md_no_down", {31'd0, key_down}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("md_rst_row", {28'd0, row_out}, 32'hE);
    chk("md_rst_code", {28'd0, key_code}, 32'h0);
    chk("md_rst_valid", {31'd0, key_valid}, 32'h0);
    chk("md_rst_down", {31'd0, key_down}, 32'h0);
    key_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // reset while HELD
    key_row  = 2'd1;
    key_mask = 4'b0100;
    exp_q.push_back(4'h6);
    key_en   = 1'b1;
    wait_down(1'b1, "hr_down");
    rst    = 1'b1;
    key_en = 1'b0;
    @(negedge clk);
    chk("hr_rst_down", {31'd0, key_down}, 32'h0);
    chk("hr_rst_code", {28'd0, key_code}, 32'h0);
    chk("hr_rst_row", {28'd0, row_out}, 32'hE);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
